// File: rtl/uart_rx_autobaud.sv
// Auto-baud UART receiver: calibrates on a 0x55 start bit, then receives N-P-S frames.
// Optional UART_RX_MAJORITY_EN: 3-sample majority vote around each bit centre.
`timescale 1ns/1ps
module uart_rx_autobaud #(
   parameter int COUNTER_WIDTH = 24,
   parameter int DATA_BITS     = 8,
   parameter int PARITY_MODE   = 0,
   parameter int STOP_BITS     = 1,
   parameter int MIN_CYCLES    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx_in,
   output logic [DATA_BITS-1:0]     data,
   output logic                     data_valid,
   output logic                     frame_err,
   output logic                     parity_err,
   output logic [COUNTER_WIDTH-1:0] cycles_per_bit,
   output logic                     baud_locked
);

   localparam int CW = COUNTER_WIDTH;
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] T_MAX     = '1;
   localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_CYCLES);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE, CAL, CAL_FLUSH, START, DATA, PARITY, STOP
   } state_t;

   state_t state, state_n;

   logic rx_s1, rx_s2, rx_prev;
   logic fall, rise, sample;
   logic [CW-1:0] timer, timer_n, half, last, tick;
   logic at_mid, at_end;
   logic [BW-1:0] bit_cnt, bit_cnt_n;
   logic [DATA_BITS-1:0] shreg;
   logic par_bit, stop_low, par_fail;
   logic lock_en, shift_en, par_en, stop_en, deliver;

   assign fall   = rx_prev & ~rx_s2;
   assign rise   = ~rx_prev & rx_s2;
   assign half   = cycles_per_bit >> 1;
   assign last   = cycles_per_bit - 1'b1;
   assign at_mid = (timer == half);
   assign at_end = (timer == last);
   assign tick   = at_end ? '0 : timer + 1'b1;

`ifdef UART_RX_MAJORITY_EN
   // rx_prev holds the half-1 sample, rx_s1 is what rx_s2 becomes at half+1
   assign sample = (rx_prev & rx_s2) | (rx_prev & rx_s1) | (rx_s2 & rx_s1);
`else
   assign sample = rx_s2;
`endif

   assign par_fail = (PARITY_MODE == 0) ? 1'b0 :
                     (PARITY_MODE == 1) ? (par_bit ^ (^shreg)) :
                                          (par_bit ^ (~(^shreg)));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      bit_cnt_n = bit_cnt;
      lock_en   = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
      stop_en   = 1'b0;
      deliver   = 1'b0;
      unique case (state)
         IDLE: begin
            timer_n = '0;
            if (fall) begin
               // the cycle that revealed the edge is already part of the low time
               state_n = baud_locked ? START : CAL;
               timer_n = baud_locked ? '0 : CW'(1);
            end
         end
         CAL: begin
            if (rise) begin
               state_n = (timer >= MIN_CNT) ? CAL_FLUSH : IDLE;
               lock_en = (timer >= MIN_CNT);
               timer_n = (timer >= MIN_CNT) ? CW'(1) : '0;
            end else if (timer == T_MAX) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         CAL_FLUSH: begin
            if (!rx_s2) begin
               timer_n = '0;
            end else if (({1'b0, timer} + 1'b1) >= {cycles_per_bit, 1'b0}) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         START: begin
            timer_n = tick;
            if (at_mid && sample) begin
               state_n = IDLE;
               timer_n = '0;
            end else if (at_end) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            timer_n  = tick;
            shift_en = at_mid;
            if (at_end) begin
               if (bit_cnt == LAST_DATA) begin
                  state_n   = (PARITY_MODE != 0) ? PARITY : STOP;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            timer_n = tick;
            par_en  = at_mid;
            if (at_end) begin
               state_n   = STOP;
               bit_cnt_n = '0;
            end
         end
         STOP: begin
            timer_n = tick;
            if (at_mid && bit_cnt == LAST_STOP) begin
               // leave at mid-stop so the next start edge is caught
               deliver = 1'b1;
               state_n = IDLE;
               timer_n = '0;
            end else begin
               stop_en = at_mid;
               if (at_end) bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_s1          <= 1'b1;
         rx_s2          <= 1'b1;
         rx_prev        <= 1'b1;
         timer          <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
         par_bit        <= 1'b0;
         stop_low       <= 1'b0;
         data           <= '0;
         data_valid     <= 1'b0;
         frame_err      <= 1'b0;
         parity_err     <= 1'b0;
         cycles_per_bit <= '1;
         baud_locked    <= 1'b0;
      end else begin
         rx_s1      <= rx_in;
         rx_s2      <= rx_s1;
         rx_prev    <= rx_s2;
         timer      <= timer_n;
         bit_cnt    <= bit_cnt_n;
         data_valid <= deliver;
         if (lock_en) begin
            cycles_per_bit <= timer;
            baud_locked    <= 1'b1;
         end
         if (state == IDLE) stop_low <= 1'b0;
         if (shift_en) shreg <= {sample, shreg[DATA_BITS-1:1]};
         if (par_en) par_bit <= sample;
         if (stop_en && !sample) stop_low <= 1'b1;
         if (deliver) begin
            data       <= shreg;
            frame_err  <= stop_low | ~sample;
            parity_err <= par_fail;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_autobaud.sv
// Bench: 8N1 DUT (u_a) and 8E2 DUT (u_b) driven by a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_rx_autobaud;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_a = 1'b1;
   logic rx_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic dv_a, dv_b, fe_a, fe_b, pe_a, pe_b, lk_a, lk_b;
   logic [23:0] cpb_a, cpb_b;

   always #5 clk = ~clk;

   uart_rx_autobaud u_a (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_a),
      .data(data_a), .data_valid(dv_a), .frame_err(fe_a),
      .parity_err(pe_a), .cycles_per_bit(cpb_a), .baud_locked(lk_a)
   );

   uart_rx_autobaud #(.PARITY_MODE(1), .STOP_BITS(2)) u_b (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_b),
      .data(data_b), .data_valid(dv_b), .frame_err(fe_b),
      .parity_err(pe_b), .cycles_per_bit(cpb_b), .baud_locked(lk_b)
   );

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      longint     t;
   } rec_t;

   rec_t got_a[$], got_b[$], exp_a[$], exp_b[$];
   int checks = 0;
   int errors = 0;
   int bt = 16;
   logic dv_a_q = 1'b0;
   logic dv_b_q = 1'b0;
   logic wide = 1'b0;

   always @(posedge clk) begin
      #1;
      if (dv_a) got_a.push_back('{data_a, fe_a, pe_a, $time - 1});
      if (dv_b) got_b.push_back('{data_b, fe_b, pe_b, $time - 1});
      if ((dv_a && dv_a_q) || (dv_b && dv_b_q)) wide <= 1'b1;
      dv_a_q <= dv_a;
      dv_b_q <= dv_b;
   end

   function automatic int build(input logic [7:0] d, input int pm, input int sb,
                                input bit bad_par, input bit stop_lo,
                                output logic [15:0] v);
      int n;
      logic p;
      v = '1;
      n = 0;
      v[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         v[n] = d[i];
         n++;
      end
      if (pm != 0) begin
         p = (pm == 1) ? (^d) : (~(^d));
         v[n] = p ^ bad_par;
         n++;
      end
      for (int s = 0; s < sb; s++) begin
         v[n] = !(stop_lo && s == sb - 1);
         n++;
      end
      return n;
   endfunction

   task automatic set_line(input int u, input logic b);
      if (u == 0) rx_a = b;
      else        rx_b = b;
   endtask

   task automatic send(input int u, input logic [7:0] d, input bit bad_par,
                       input bit stop_lo, input int idle_bits, input bit cal,
                       input int spike);
      logic [15:0] v;
      int n;
      rec_t e;
      n = build(d, (cal || u == 0) ? 0 : 1, (cal || u == 0) ? 1 : 2,
                bad_par, stop_lo, v);
      e.d  = d;
      e.fe = stop_lo;
      e.pe = bad_par && (u == 1);
      e.t  = $time + 5 + 10 * (3 + n * bt - bt / 2);
      if (!cal) begin
         if (u == 0) exp_a.push_back(e);
         else        exp_b.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         set_line(u, v[i]);
         if (i == spike) begin
            repeat (bt / 2) @(negedge clk);
            set_line(u, ~v[i]);
            @(negedge clk);
            set_line(u, v[i]);
            repeat (bt - bt / 2 - 1) @(negedge clk);
         end else begin
            repeat (bt) @(negedge clk);
         end
      end
      set_line(u, 1'b1);
      repeat (idle_bits * bt) @(negedge clk);
   endtask

   task automatic clear_q();
      got_a.delete();
      got_b.delete();
      exp_a.delete();
      exp_b.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (data_a !== 8'h00 || dv_a !== 1'b0 || fe_a !== 1'b0 || pe_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a_out got %h %b %b %b want 00 0 0 0", data_a, dv_a, fe_a, pe_a);
      end
      checks++;
      if (cpb_a !== 24'hFFFFFF || lk_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_a_baud got %h %b want ffffff 0", cpb_a, lk_a);
      end
      checks++;
      if (data_b !== 8'h00 || dv_b !== 1'b0 || pe_b !== 1'b0 || cpb_b !== 24'hFFFFFF || lk_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_b got %h %b %b %h %b", data_b, dv_b, pe_b, cpb_b, lk_b);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_calibrate();
      clear_q();
      send(0, 8'h55, 0, 0, 3, 1, -1);
      send(1, 8'h55, 0, 0, 3, 1, -1);
      checks++;
      if (cpb_a !== 24'd16 || lk_a !== 1'b1) begin
         errors++;
         $display("FAIL cal_a got %0d %b want 16 1", cpb_a, lk_a);
      end
      checks++;
      if (cpb_b !== 24'd16 || lk_b !== 1'b1) begin
         errors++;
         $display("FAIL cal_b got %0d %b want 16 1", cpb_b, lk_b);
      end
      checks++;
      if (got_a.size() + got_b.size() !== 0) begin
         errors++;
         $display("FAIL cal_no_valid got %0d pulses want 0", got_a.size() + got_b.size());
      end
   endtask

   task automatic test_data(input int idle);
      longint dt;
      clear_q();
      if (idle > 0) send(0, 8'hA3, 0, 0, idle, 0, -1);
      for (int k = 0; k < 6; k++) send(0, 8'($urandom_range(255)), 0, 0, idle, 0, -1);
      checks++;
      if (got_a.size() !== exp_a.size()) begin
         errors++;
         $display("FAIL data_count got %0d want %0d", got_a.size(), exp_a.size());
      end
      foreach (exp_a[i]) begin
         if (i < got_a.size()) begin
            checks++;
            if (got_a[i].d !== exp_a[i].d || got_a[i].fe !== 1'b0 || got_a[i].pe !== 1'b0) begin
               errors++;
               $display("FAIL data[%0d] got %h fe%b pe%b want %h fe0 pe0",
                        i, got_a[i].d, got_a[i].fe, got_a[i].pe, exp_a[i].d);
            end
            dt = got_a[i].t - exp_a[i].t;
            checks++;
            if (dt > 10 || dt < -10) begin
               errors++;
               $display("FAIL latency[%0d] got %0d want %0d (ns)", i, got_a[i].t, exp_a[i].t);
            end
         end
      end
      checks++;
      if (wide !== 1'b0) begin
         errors++;
         $display("FAIL valid_width got multi-cycle pulse want one cycle");
      end
   endtask

   task automatic test_parity();
      bit bp;
      longint dt;
      clear_q();
      send(1, 8'h07, 1, 0, 1, 0, -1);
      send(1, 8'h07, 0, 0, 1, 0, -1);
      for (int k = 0; k < 6; k++) begin
         bp = 1'($urandom_range(1));
         send(1, 8'($urandom_range(255)), bp, 0, k % 2, 0, -1);
      end
      checks++;
      if (got_b.size() !== exp_b.size()) begin
         errors++;
         $display("FAIL parity_count got %0d want %0d", got_b.size(), exp_b.size());
      end
      foreach (exp_b[i]) begin
         if (i < got_b.size()) begin
            checks++;
            if (got_b[i].d !== exp_b[i].d || got_b[i].pe !== exp_b[i].pe || got_b[i].fe !== 1'b0) begin
               errors++;
               $display("FAIL parity[%0d] got %h pe%b fe%b want %h pe%b fe0",
                        i, got_b[i].d, got_b[i].pe, got_b[i].fe, exp_b[i].d, exp_b[i].pe);
            end
            dt = got_b[i].t - exp_b[i].t;
            checks++;
            if (dt > 10 || dt < -10) begin
               errors++;
               $display("FAIL parity_latency[%0d] got %0d want %0d (ns)", i, got_b[i].t, exp_b[i].t);
            end
         end
      end
   endtask

   task automatic test_framing();
      clear_q();
      send(0, 8'h3C, 0, 1, 2, 0, -1);
      send(0, 8'h3C, 0, 0, 2, 0, -1);
      send(1, 8'hC5, 0, 1, 2, 0, -1);
      send(1, 8'hC5, 0, 0, 2, 0, -1);
      checks++;
      if (got_a.size() !== 2 || got_b.size() !== 2) begin
         errors++;
         $display("FAIL frame_count got %0d/%0d want 2/2", got_a.size(), got_b.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_a[i].d !== exp_a[i].d || got_a[i].fe !== exp_a[i].fe) begin
               errors++;
               $display("FAIL frame_a[%0d] got %h fe%b want %h fe%b",
                        i, got_a[i].d, got_a[i].fe, exp_a[i].d, exp_a[i].fe);
            end
            checks++;
            if (got_b[i].d !== exp_b[i].d || got_b[i].fe !== exp_b[i].fe) begin
               errors++;
               $display("FAIL frame_b[%0d] got %h fe%b want %h fe%b",
                        i, got_b[i].d, got_b[i].fe, exp_b[i].d, exp_b[i].fe);
            end
         end
      end
   endtask

   task automatic test_glitch();
      clear_q();
      rx_a = 1'b0;
      repeat (3) @(negedge clk);
      rx_a = 1'b1;
      repeat (3 * bt) @(negedge clk);
      checks++;
      if (got_a.size() !== 0) begin
         errors++;
         $display("FAIL glitch_valid got %0d pulses want 0", got_a.size());
      end
      send(0, 8'h5A, 0, 0, 2, 0, -1);
      checks++;
      if (got_a.size() !== 1 || got_a[0].d !== 8'h5A) begin
         errors++;
         $display("FAIL glitch_recover got %0d pulses want 1 of 5a", got_a.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      clear_q();
      rx_a = 1'b0;
      repeat (bt) @(negedge clk);
      rx_a = 1'b1;
      repeat (3 * bt + bt / 2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (data_a !== 8'h00 || dv_a !== 1'b0 || fe_a !== 1'b0 || cpb_a !== 24'hFFFFFF || lk_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got %h %b %b %h %b want 00 0 0 ffffff 0",
                  data_a, dv_a, fe_a, cpb_a, lk_a);
      end
      rst_n = 1'b1;
      repeat (3 * bt) @(negedge clk);
      rx_a = 1'b0;
      repeat (2) @(negedge clk);
      rx_a = 1'b1;
      repeat (2 * bt) @(negedge clk);
      checks++;
      if (lk_a !== 1'b0 || cpb_a !== 24'hFFFFFF || got_a.size() !== 0) begin
         errors++;
         $display("FAIL unlocked_glitch got lock%b %h n%0d want 0 ffffff 0", lk_a, cpb_a, got_a.size());
      end
      bt = 12;
      send(0, 8'h55, 0, 0, 3, 1, -1);
      checks++;
      if (cpb_a !== 24'd12 || lk_a !== 1'b1) begin
         errors++;
         $display("FAIL recal got %0d %b want 12 1", cpb_a, lk_a);
      end
      d = 8'($urandom_range(255));
      send(0, d, 0, 0, 2, 0, -1);
      checks++;
      if (got_a.size() !== 1 || got_a[0].d !== d) begin
         errors++;
         $display("FAIL recal_data got n%0d want 1 of %h", got_a.size(), d);
      end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_spike();
      clear_q();
      send(0, 8'hF0, 0, 0, 2, 0, 3);
      send(0, 8'h0F, 0, 0, 2, 0, 2);
      checks++;
      if (got_a.size() !== 2 || got_a[0].d !== 8'hF0 || got_a[1].d !== 8'h0F) begin
         errors++;
         $display("FAIL spike got n%0d want f0 0f", got_a.size());
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_calibrate();
      test_data(1);
      test_data(0);
      test_parity();
      test_framing();
      test_glitch();
`ifdef UART_RX_MAJORITY_EN
      test_spike();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_autobaud.md
Name: uart_rx_autobaud

Overview:
Parametrised successor to the fixed 8N1 auto-baud UART receiver, feeding the program loader.
- Measures bit period from the start bit of a calibration character.
- Receives frames of DATA_BITS data bits, optional parity and 1 or 2 stop bits.
- Flags framing and parity errors; rejects false starts and glitches.
- Delivers each character as a one-cycle valid pulse.

Parameters:
COUNTER_WIDTH, 24, width of bit-period timer and cycles_per_bit
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
PARITY_MODE, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, legal 1 or 2
MIN_CYCLES, 4, smallest accepted measured bit period

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
rx_in  in  1  asynchronous serial line, idle high
data  out  DATA_BITS  last received character, held until next data_valid
data_valid  out  1  one-cycle pulse, new character on data
frame_err  out  1  stop bit(s) sampled low for the character on data
parity_err  out  1  parity mismatch for the character on data, 0 if PARITY_MODE=0
cycles_per_bit  out  COUNTER_WIDTH  measured bit period in clk cycles
baud_locked  out  1  bit period measured and valid

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; all state updates on posedge clk.
- Reset (rst_n=0 at a clk edge) values: data=0, data_valid=0, frame_err=0, parity_err=0, cycles_per_bit=all ones, baud_locked=0, FSM=IDLE, timer=0.
- Reset mid-frame aborts the frame with no data_valid and clears baud_locked.
- rx_in passes through a 2-flop synchronizer. Falling/rising edges are detected on the synchronized signal.
- Timer counts 0..cycles_per_bit-1 within each bit. Mid-sample at timer == cycles_per_bit>>1; bit advance at timer == cycles_per_bit-1.
- FSM states: IDLE, CAL, CAL_FLUSH, START, DATA, PARITY, STOP.
- IDLE:
  - Falling edge with baud_locked=0 -> CAL.
  - Falling edge with baud_locked=1 -> START.
  - Timer held at 0.
- CAL:
  - Timer counts while line low.
  - On rising edge, if count >= MIN_CYCLES: cycles_per_bit <= count, baud_locked <= 1, -> CAL_FLUSH.
  - On rising edge, if count < MIN_CYCLES: glitch, -> IDLE, nothing updated.
  - Timer saturates at all ones; on saturation -> IDLE, not locked.
- CAL_FLUSH:
  - Timer counts while line high; any low resets the timer.
  - At 2*cycles_per_bit continuous high -> IDLE.
  - The calibration character is never delivered. Host sends 0x55, then idles >= 2 bit times after its stop bit.
- START: mid-sample high = false start, -> IDLE. Otherwise -> DATA at bit advance.
- DATA:
  - Mid-sample shifts into data register, LSB first.
  - After DATA_BITS bits -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: mid-sample compared against XOR of data bits (even) or its inverse (odd).
- STOP:
  - Each stop bit is mid-sampled.
  - At mid-sample of the last stop bit: data, frame_err (any stop low), parity_err update; data_valid=1 for one cycle; FSM -> IDLE immediately.
  - The back half of the stop bit therefore accepts the next start edge, so back-to-back frames are received.
- Latency: data_valid rises 3 clk cycles + (1+DATA_BITS+P+STOP_BITS-0.5)*cycles_per_bit after the rx_in falling edge, where P=1 if parity is enabled, else 0. Tolerance ±1 cycle.
- A frame with frame_err still pulses data_valid. Consumers decide whether to drop it.
- Falling edges outside IDLE are ignored.
- cycles_per_bit is re-measured only after reset.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each mid-sample is the majority of synchronized rx_in at timer == half-1, half and half+1. This applies to start, data, parity and stop bits. Requires cycles_per_bit >= 4, which is guaranteed by MIN_CYCLES.
- Undefined: single sample at timer == half.
- Timing and outputs are otherwise identical.

Test Plan:
- Reset, then 0x55 at 16 clk/bit -> cycles_per_bit=16, baud_locked=1, no data_valid.
- Locked at 16, send 0xA3 8N1 -> data=0xA3, data_valid one cycle, frame_err=0, parity_err=0; latency within ±1 of 3+9.5*16=155 cycles.
- PARITY_MODE=1, send 0x07 with parity bit 0 -> data=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Send 0x3C with stop bit forced low -> data_valid, frame_err=1. Following 0x3C sent correctly -> frame_err=0.
- Locked, 3-cycle low glitch on rx_in -> no data_valid, FSM back in IDLE. Unlocked, 2-cycle glitch -> baud_locked stays 0.
- rst_n low for one cycle mid-data-bit -> all outputs at reset values; next 0x55 re-calibrates. With UART_RX_MAJORITY_EN, a one-cycle inverted spike at mid-bit is ignored.
